// File: rtl/arbiter_crp_harvester.sv
// Challenge-response harvester for an arbiter PUF.
// LFSR challenges, settle/fire timing, and packed response stream.
module arbiter_crp_harvester #(
  parameter int N      = 128,
  parameter int RESP_W = 32,
  parameter int SETTLE = 4,
  parameter logic [N-1:0] TAPS = N'((128'd1 << 127) | (128'd1 << 125) |
                                    (128'd1 << 100) | (128'd1 << 98)),
  parameter logic [N-1:0] SEED = N'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       num_words,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      puf_sel,
  output logic              puf_in,
  input  logic              puf_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data
);

  localparam logic [N-1:0] SEED_EFF = (SEED == '0) ? N'(1) : SEED;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int BW = $clog2(RESP_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_FIRE,
    S_SAMPLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [N-1:0]       r_lfsr;
  logic [N-1:0]       r_sel;
  logic               r_in;
  logic [RESP_W-1:0]  r_shift;
  logic [RESP_W-1:0]  r_data;
  logic               r_valid;
  logic [BW-1:0]      r_bits;
  logic [15:0]        r_words;
  logic [15:0]        r_num;
  logic [CW-1:0]      r_cnt;

  logic               w_fb;
  logic [N-1:0]       w_lfsr_nx;
  logic               w_settled;
  logic               w_last_bit;
  logic               w_last_word;
  logic               w_xfer;

  assign w_fb        = ^(r_lfsr & TAPS);
  assign w_lfsr_nx   = {r_lfsr[N-2:0], w_fb};
  assign w_settled   = (r_cnt == CW'(SETTLE - 1));
  assign w_last_bit  = (r_bits == BW'(RESP_W - 1));
  assign w_last_word = ((r_words + 16'd1) == r_num);
  assign w_xfer      = r_valid & resp_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (num_words == 16'd0) ? S_DONE : S_APPLY;
        end
      end
      S_APPLY: begin
        if (w_settled) begin
          w_next = S_FIRE;
        end
      end
      S_FIRE: begin
        if (w_settled) begin
          w_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_next = w_last_bit ? S_EMIT : S_APPLY;
      end
      S_EMIT: begin
        if (w_xfer) begin
          w_next = w_last_word ? S_DONE : S_APPLY;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED_EFF;
      r_sel   <= '0;
      r_in    <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_bits  <= '0;
      r_words <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_in    <= (w_next == S_FIRE);
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num   <= num_words;
            r_lfsr  <= SEED_EFF;
            r_bits  <= '0;
            r_words <= '0;
            if (w_next == S_APPLY) begin
              r_sel <= SEED_EFF;
            end
          end
        end
        S_SAMPLE: begin
          r_shift <= {r_shift[RESP_W-2:0], puf_out};
          r_bits  <= r_bits + BW'(1);
          r_lfsr  <= w_lfsr_nx;
          if (w_next == S_APPLY) begin
            r_sel <= w_lfsr_nx;
          end
        end
        S_EMIT: begin
          // First EMIT cycle registers the word; valid rises on the next edge.
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_data  <= r_shift;
          end else if (resp_ready) begin
            r_valid <= 1'b0;
            r_words <= r_words + 16'd1;
            r_bits  <= '0;
            if (w_next == S_APPLY) begin
              r_sel <= r_lfsr;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign puf_sel    = r_sel;
  assign puf_in     = r_in;
  assign resp_valid = r_valid;
  assign resp_data  = r_data;

endmodule
